// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and sampling helper for the UART
// receive path.
package uart_pkg;

  localparam int unsigned CLK_DIV_DEFAULT   = 651;
  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned SAMPLE_TICK_FIRST = 7;
  localparam int unsigned SAMPLE_TICK_MID   = 8;
  localparam int unsigned SAMPLE_TICK_LAST  = 9;
  localparam int unsigned BITS_PER_BYTE     = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting,
// feeding a byte FIFO with overrun and framing-error pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  rx_state_t     state;
  rx_state_t     next;
  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic [3:0]    tick_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          s7;
  logic          s8;
  logic          tick;
  logic          decide;
  logic          bit_end;
  logic          maj;
  logic          start_enter;
  logic          shift_en;
  logic          push;
  logic          fe_set;
  logic          fifo_full;
  logic          fifo_empty;

  assign tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign decide  = tick && (tick_idx == 4'(SAMPLE_TICK_LAST));
  assign bit_end = tick && (tick_idx == 4'(OVERSAMPLE - 1));
  assign maj     = majority3(s7, s8, rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (!rx_s) next = START;
      START:     if (decide && maj) next = IDLE;
                 else if (bit_end)  next = DATA;
      DATA:      if (bit_end && bit_idx == 3'(BITS_PER_BYTE - 1)) next = STOP;
      STOP:      if (decide) next = maj ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_comb begin
    start_enter = (state == IDLE) && !rx_s;
    shift_en    = (state == DATA) && decide;
    push        = (state == STOP) && decide && maj;
    fe_set      = (state == STOP) && decide && !maj;
    busy        = (state != IDLE);
  end

  // The divider and tick index restart together so tick 0 lands one divider
  // period after the falling edge was seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      div_cnt   <= '0;
      tick_idx  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (start_enter || tick) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DW'(1);
      if (start_enter) tick_idx <= '0;
      else if (tick)   tick_idx <= tick_idx + 4'd1;
      if (tick && tick_idx == 4'(SAMPLE_TICK_FIRST)) s7 <= rx_s;
      if (tick && tick_idx == 4'(SAMPLE_TICK_MID))   s8 <= rx_s;
      if (state == START)                bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {maj, shreg[7:1]};
      frame_err <= fe_set;
      overrun   <= push && fifo_full && !rd_en;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (rd_en),
    .wr_data (shreg),
    .data    (rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: cycle-accurate behavioural receiver/FIFO model
// derived from line history, checked every cycle, plus directed scenarios.
module tb_uart_rx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 8;
  localparam int BITP  = 16 * D;
  localparam int HMAX  = 1 << 17;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_fifo #(
    .CLK_DIV    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a frame starts on the first idle edge where the synchronized line
  // is low; tick k of frame bit b acts at edge s0 + (16*b + k + 1)*D.
  typedef enum {M_IDLE, M_RECV, M_WAIT} mstate_t;
  mstate_t    m_st = M_IDLE;
  bit         hist [HMAX];
  int         ne = 0;
  int         s0 = 0;
  logic [7:0] m_byte = '0;
  logic [7:0] mq [$];
  bit         exp_fe = 1'b0;
  bit         exp_ov = 1'b0;

  function automatic bit rxs(input int e);
    if (e < 2) return 1'b1;
    return hist[(e - 2) % HMAX];
  endfunction

  always @(posedge clk) begin : model
    bit push, pop, maj;
    int rel, t, b, k;
    hist[ne % HMAX] = rst ? rx : 1'b1;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    push   = 1'b0;
    if (!rst) begin
      m_st = M_IDLE;
      mq.delete();
    end else begin
      case (m_st)
        M_IDLE: if (!rxs(ne)) begin m_st = M_RECV; s0 = ne; end
        M_RECV: begin
          rel = ne - s0;
          if (rel % D == 0) begin
            t = rel / D - 1;
            b = t / 16;
            k = t % 16;
            if (k == 9) begin
              maj = (int'(rxs(ne - 2 * D)) + int'(rxs(ne - D)) + int'(rxs(ne))) >= 2;
              if (b == 0) begin
                if (maj) m_st = M_IDLE;
              end else if (b <= 8) begin
                m_byte[b - 1] = maj;
              end else begin
                if (maj) begin push = 1'b1; m_st = M_IDLE; end
                else begin exp_fe = 1'b1; m_st = M_WAIT; end
              end
            end
          end
        end
        default: if (rxs(ne)) m_st = M_IDLE;
      endcase
      pop = rd_en && (mq.size() > 0);
      if (push && mq.size() == DEPTH && !pop) begin
        exp_ov = 1'b1;
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(m_byte);
      end
    end
    ne++;
  end

  // rd_mode: 0 idle, 1 random, 2 continuous, 3 only on the predicted push edge.
  int rd_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0:       rd_en = 1'b0;
      1:       rd_en = ($urandom_range(0, 3) == 0);
      2:       rd_en = 1'b1;
      default: rd_en = (m_st == M_RECV) && (ne == s0 + 154 * D);
    endcase
  end

  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] popped [$];

  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rd_en && rd_valid) popped.push_back(rd_data);
      chk("rd_valid", int'(rd_valid), int'(mq.size() != 0));
      chk("count", int'(count), mq.size());
      chk("busy", int'(busy), int'(m_st != M_IDLE));
      chk("frame_err", int'(frame_err), int'(exp_fe));
      chk("overrun", int'(overrun), int'(exp_ov));
      if (mq.size() != 0) chk("rd_data", int'(rd_data), int'(mq[0]));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] b);
    rx = 1'b0;
    cyc(BITP);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BITP);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int tail, input int gap);
    send_bits(b);
    rx = good;
    cyc(BITP);
    if (!good) cyc(tail);
    rx = 1'b1;
    cyc(gap);
  endtask

  task automatic drain();
    rd_mode = 2;
    cyc(DEPTH + 3);
    rd_mode = 0;
    cyc(3);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    cyc(5);
    chk("reset count", int'(count), 0);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset busy", int'(busy), 0);

    // Single good frame.
    send_frame(8'h55, 1'b1, 0, BITP);
    chk("0x55 rd_valid", int'(rd_valid), 1);
    chk("0x55 rd_data", int'(rd_data), 8'h55);
    chk("0x55 count", int'(count), 1);
    chk("0x55 frame_err", fe_cnt, 0);
    drain();

    // False start.
    fe_cnt = 0;
    rx = 1'b0;
    cyc(4 * D);
    rx = 1'b1;
    cyc(BITP);
    chk("false start busy", int'(busy), 0);
    chk("false start count", int'(count), 0);
    chk("false start frame_err", fe_cnt, 0);

    // Framing error, line held low afterwards.
    fe_cnt = 0;
    send_bits(8'hA3);
    rx = 1'b0;
    cyc(3 * BITP);
    chk("break busy", int'(busy), 1);
    rx = 1'b1;
    cyc(BITP);
    chk("break busy released", int'(busy), 0);
    chk("break frame_err pulses", fe_cnt, 1);
    chk("break count", int'(count), 0);

    // Overfill by one.
    ov_cnt = 0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 0, 4 * D);
    chk("overfill count", int'(count), 8);
    chk("overfill overrun pulses", ov_cnt, 1);
    popped.delete();
    drain();
    chk("overfill pops", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) chk("overfill order", int'(popped[i]), i + 1);

    // Push into full FIFO with simultaneous pop.
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 0, 4 * D);
    ov_cnt = 0;
    popped.delete();
    rd_mode = 3;
    send_frame(8'h10, 1'b1, 0, 4 * D);
    rd_mode = 0;
    cyc(3);
    chk("full push+pop count", int'(count), 8);
    chk("full push+pop overrun", ov_cnt, 0);
    chk("full push+pop popped", popped.size(), 1);
    popped.delete();
    drain();
    chk("full push+pop drain", popped.size(), 8);
    if (popped.size() == 8) chk("full push+pop last", int'(popped[7]), 8'h10);

    // Reset during data bit 4.
    send_frame(8'h77, 1'b1, 0, BITP);
    fork
      send_frame(8'hF5, 1'b1, 0, BITP);
      begin
        cyc(5 * BITP + BITP / 2);
        rst = 1'b0;
        cyc(4);
        rst = 1'b1;
      end
    join
    chk("post-reset count", int'(count), 0);
    chk("post-reset busy", int'(busy), 0);
    send_frame(8'h3C, 1'b1, 0, BITP);
    chk("post-reset rd_data", int'(rd_data), 8'h3C);
    chk("post-reset count after frame", int'(count), 1);
    drain();

    // Random traffic with random reads.
    rd_mode = 1;
    for (int f = 0; f < 24; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rx = 1'b0;
        cyc($urandom_range(1, 6 * D));
        rx = 1'b1;
        cyc(BITP);
      end else if (r == 1) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(0, 2 * BITP), $urandom_range(1, BITP));
      end else begin
        send_frame(8'($urandom), 1'b1, 0, $urandom_range(0, BITP));
      end
    end
    rd_mode = 0;
    cyc(2 * BITP);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 651, meaning clk cycles per 16x oversample tick (100 MHz / (9600*16)).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte buffer entries (power of two).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 SHALL have port rd_en  input  1  pop request for the FIFO head.
REQ-007 SHALL have port rd_data  output  8  FIFO head byte (first-word fall-through); valid while rd_valid=1.
REQ-008 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-009 SHALL have port count  output  4  FIFO occupancy, 0..FIFO_DEPTH.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit samples 0.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 SHALL generate a one-cycle tick every CLK_DIV clk cycles from a free-running divider that restarts at 0 on entry to START.
REQ-015 SHALL run FSM states IDLE, START, DATA, STOP, WAIT_IDLE; each bit period is 16 ticks indexed 0..15.
REQ-016 SHALL leave IDLE for START on the first clk cycle with rx_s=0.
REQ-017 SHALL take each bit value as the majority of rx_s at ticks 7, 8, 9; the decision is made at tick 9.
REQ-018 SHALL return from START to IDLE (false start, nothing pushed, no error) if the start-bit majority is 1; otherwise it SHALL enter DATA after tick 15.
REQ-019 SHALL shift 8 data bits LSB first in DATA, one per bit period, then enter STOP.
REQ-020 SHALL, in STOP with majority 1, push the byte at tick 9 and enter IDLE on the same cycle, without waiting for ticks 10..15.
REQ-021 SHALL, in STOP with majority 0, pulse frame_err, discard the byte, and enter WAIT_IDLE, which exits to IDLE on the first rx_s=1.
REQ-022 SHALL raise rd_valid one clk cycle after the push, with rd_data equal to the oldest unread byte.
REQ-023 SHALL pop on a clk edge when rd_en=1 and rd_valid=1; rd_en while empty SHALL be ignored with no state change.
REQ-024 SHALL, on a push while full with no pop, drop the new byte, pulse overrun, and leave the contents unchanged.
REQ-025 SHALL, on a simultaneous push and pop while full, perform both; count stays FIFO_DEPTH and overrun stays 0.
REQ-026 SHALL, on a simultaneous push and pop while not empty and not full, leave count unchanged.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH and preserve byte order across the wrap.

Reset
REQ-028 SHALL, while rst=0, force FSM=IDLE, divider=0, tick index=0, shift register=0, pointers=0, count=0, rd_valid=0, frame_err=0, overrun=0, busy=0, and synchronizer flops=1.
REQ-029 SHALL discard a frame in progress when reset is asserted mid-frame; after release it SHALL resynchronize on the next falling edge of rx_s.
REQ-030 SHALL leave rd_data don't-care while rd_valid=0.

Structure
REQ-031 SHALL define CLK_DIV default, OVERSAMPLE=16, SAMPLE_TICK=7..9 and the FSM state encoding in shared package uart_pkg.
REQ-032 SHALL implement the FIFO as sub-module byte_fifo (push, pop, data, count, full, empty) with the same clk/rst.

Verification
REQ-033 SHALL cover: frame of 0x55 at 9600 baud -> one push, rd_valid=1, rd_data=0x55, count=1, frame_err=0.
REQ-034 SHALL cover: rx low for 4 ticks then high -> FSM back in IDLE, count=0, no frame_err.
REQ-035 SHALL cover: frame of 0xA3 with stop bit 0 -> a single frame_err pulse, count=0, busy until rx returns high.
REQ-036 SHALL cover: 9 frames 0x01..0x09 with rd_en=0 -> count=8, one overrun pulse on the ninth, then pops return 0x01..0x08 in order.
REQ-037 SHALL cover: FIFO full and rd_en=1 on the push cycle of 0x10 -> count=8, overrun=0, last pop returns 0x10.
REQ-038 SHALL cover: rst pulsed low during data bit 4 -> count=0, busy=0, and the next 0x3C frame is received correctly.
